// File: rtl/player_action_pkg.sv
// Shared encodings for the per-player action sequencer: state codes,
// controller bit positions, move_dir codes and the registered flag bundle.
package player_action_pkg;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] ST_IDLE    = 4'd0;
  localparam logic [STATE_W-1:0] ST_WALK    = 4'd1;
  localparam logic [STATE_W-1:0] ST_CROUCH  = 4'd2;
  localparam logic [STATE_W-1:0] ST_JUMP    = 4'd3;
  localparam logic [STATE_W-1:0] ST_WINDUP  = 4'd4;
  localparam logic [STATE_W-1:0] ST_ACTIVE  = 4'd5;
  localparam logic [STATE_W-1:0] ST_RECOVER = 4'd6;
  localparam logic [STATE_W-1:0] ST_SHIELD  = 4'd7;
  localparam logic [STATE_W-1:0] ST_STUN    = 4'd8;

  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_ATTACK = 4;
  localparam int BTN_SHIELD = 5;
  localparam int BTN_RSVD   = 6;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  typedef struct packed {
    logic attack_live;
    logic shield_up;
    logic airborne;
    logic crouching;
  } flags_t;

  // Both or neither direction pressed resolves to no movement.
  function automatic logic [1:0] resolve_dir(input logic left, input logic right);
    logic [1:0] d;
    d = DIR_NONE;
    if (left && !right) d = DIR_LEFT;
    else if (right && !left) d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/player_action_fsm_timer.sv
// 8-bit loadable frame down-counter. Saturates at zero; expire flags the tick
// on which the count sits at 1, so a load of N lasts exactly N ticks.
module action_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       tick,
  output logic       expire,
  output logic       zero
);

  logic [7:0] cnt_q, cnt_d;
  logic       zero_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = value;
    else if (tick && cnt_q != '0) cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign expire = tick && (cnt_q == 8'd1);
  assign zero   = zero_q;

endmodule

// File: rtl/player_action_fsm.sv
// Per-player fighter action sequencer: arbitrates controller buttons once per
// frame tick and drives registered action flags and hit/block pulses.
module player_action_fsm
  import player_action_pkg::*;
#(
  parameter int JUMP_FRAMES     = 16,
  parameter int WINDUP_FRAMES   = 3,
  parameter int ACTIVE_FRAMES   = 2,
  parameter int RECOVER_FRAMES  = 6,
  parameter int SHIELD_MAX      = 90,
  parameter int SHIELD_COOLDOWN = 60,
  parameter int STUN_FRAMES     = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_tick,
  input  logic [6:0]   controller_inputs,
  input  logic         hit,
  output logic [3:0]   state,
  output logic [1:0]   move_dir,
  output logic         attack_live,
  output logic         shield_up,
  output logic         airborne,
  output logic         crouching,
  output logic         shield_ready,
  output logic         hit_taken,
  output logic         blocked
);

  localparam logic [7:0] JUMP_N    = 8'(JUMP_FRAMES);
  localparam logic [7:0] WINDUP_N  = 8'(WINDUP_FRAMES);
  localparam logic [7:0] ACTIVE_N  = 8'(ACTIVE_FRAMES);
  localparam logic [7:0] RECOVER_N = 8'(RECOVER_FRAMES);
  localparam logic [7:0] SHIELD_N  = 8'(SHIELD_MAX);
  localparam logic [7:0] COOL_N    = 8'(SHIELD_COOLDOWN);
  localparam logic [7:0] STUN_N    = 8'(STUN_FRAMES);

  logic [3:0] state_q, state_d;
  logic [1:0] jump_dir_q, jump_dir_d;
  logic [1:0] move_dir_q, move_dir_d;
  logic       attack_prev_q, attack_prev_d;
  logic       hit_pending_q, hit_pending_d;
  logic       hit_taken_q, hit_taken_d;
  logic       blocked_q, blocked_d;
  flags_t     flags_q, flags_d;

  logic       ph_load, ph_expire, cd_load;
  logic [7:0] ph_value;
  logic       ph_unused_zero, cd_unused_expire;
  logic       unused_rsvd;

  logic       hit_now, atk_req, btn_shield, btn_up, btn_down;
  logic [1:0] dir;

  assign unused_rsvd = controller_inputs[BTN_RSVD];
  assign hit_now     = hit_pending_q | hit;
  assign atk_req     = controller_inputs[BTN_ATTACK] & ~attack_prev_q;
  assign btn_shield  = controller_inputs[BTN_SHIELD];
  assign btn_up      = controller_inputs[BTN_UP];
  assign btn_down    = controller_inputs[BTN_DOWN];
  assign dir         = resolve_dir(controller_inputs[BTN_LEFT], controller_inputs[BTN_RIGHT]);

  // Shared phase timer: jump, attack phases, stun and shield usage.
  action_timer u_phase (
    .clk    (clk),
    .rst    (reset),
    .load   (ph_load),
    .value  (ph_value),
    .tick   (frame_tick),
    .expire (ph_expire),
    .zero   (ph_unused_zero)
  );

  action_timer u_cooldown (
    .clk    (clk),
    .rst    (reset),
    .load   (cd_load),
    .value  (COOL_N),
    .tick   (frame_tick),
    .expire (cd_unused_expire),
    .zero   (shield_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      jump_dir_q    <= DIR_NONE;
      move_dir_q    <= DIR_NONE;
      attack_prev_q <= 1'b0;
      hit_pending_q <= 1'b0;
      hit_taken_q   <= 1'b0;
      blocked_q     <= 1'b0;
      flags_q       <= '0;
    end else begin
      state_q       <= state_d;
      jump_dir_q    <= jump_dir_d;
      move_dir_q    <= move_dir_d;
      attack_prev_q <= attack_prev_d;
      hit_pending_q <= hit_pending_d;
      hit_taken_q   <= hit_taken_d;
      blocked_q     <= blocked_d;
      flags_q       <= flags_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    jump_dir_d    = jump_dir_q;
    attack_prev_d = attack_prev_q;
    hit_pending_d = frame_tick ? 1'b0 : (hit_pending_q | hit);
    hit_taken_d   = 1'b0;
    blocked_d     = 1'b0;
    ph_load       = 1'b0;
    ph_value      = '0;
    cd_load       = 1'b0;

    if (frame_tick) begin
      attack_prev_d = controller_inputs[BTN_ATTACK];
      if (hit_now && state_q != ST_SHIELD) begin
        state_d     = ST_STUN;
        ph_load     = 1'b1;
        ph_value    = STUN_N;
        hit_taken_d = 1'b1;
      end else begin
        case (state_q)
          ST_IDLE, ST_WALK, ST_CROUCH: begin
            if (atk_req) begin
              state_d  = ST_WINDUP;
              ph_load  = 1'b1;
              ph_value = WINDUP_N;
            end else if (btn_shield && shield_ready) begin
              state_d  = ST_SHIELD;
              ph_load  = 1'b1;
              ph_value = SHIELD_N;
            end else if (btn_up) begin
              state_d    = ST_JUMP;
              ph_load    = 1'b1;
              ph_value   = JUMP_N;
              jump_dir_d = dir;
            end else if (btn_down) begin
              state_d = ST_CROUCH;
            end else if (dir != DIR_NONE) begin
              state_d = ST_WALK;
            end else begin
              state_d = ST_IDLE;
            end
          end
          // An absorbed hit only pulses blocked; release and exhaustion still apply.
          ST_SHIELD: begin
            blocked_d = hit_now;
            if (!btn_shield || ph_expire) begin
              state_d = ST_IDLE;
              cd_load = 1'b1;
            end
          end
          ST_JUMP, ST_WINDUP, ST_ACTIVE, ST_RECOVER, ST_STUN: begin
            if (ph_expire) begin
              case (state_q)
                ST_WINDUP: begin
                  state_d  = ST_ACTIVE;
                  ph_load  = 1'b1;
                  ph_value = ACTIVE_N;
                end
                ST_ACTIVE: begin
                  state_d  = ST_RECOVER;
                  ph_load  = 1'b1;
                  ph_value = RECOVER_N;
                end
                default: state_d = ST_IDLE;
              endcase
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Outputs only move on a tick so WALK direction cannot drift between frames.
  always_comb begin
    move_dir_d = move_dir_q;
    flags_d    = flags_q;
    if (frame_tick) begin
      move_dir_d = DIR_NONE;
      if (state_d == ST_WALK)      move_dir_d = dir;
      else if (state_d == ST_JUMP) move_dir_d = jump_dir_d;
      flags_d.attack_live = (state_d == ST_ACTIVE);
      flags_d.shield_up   = (state_d == ST_SHIELD);
      flags_d.airborne    = (state_d == ST_JUMP);
      flags_d.crouching   = (state_d == ST_CROUCH);
    end
  end

  assign state       = state_q;
  assign move_dir    = move_dir_q;
  assign attack_live = flags_q.attack_live;
  assign shield_up   = flags_q.shield_up;
  assign airborne    = flags_q.airborne;
  assign crouching   = flags_q.crouching;
  assign hit_taken   = hit_taken_q;
  assign blocked     = blocked_q;

endmodule

// File: tb/tb_player_action_fsm.sv
// Directed bench for player_action_fsm with a frame-level reference model
// compared against the DUT on every clock.
module tb_player_action_fsm;
  import player_action_pkg::*;

  localparam int P_JUMP = 16, P_WIND = 3, P_ACT = 2, P_REC = 6;
  localparam int P_SMAX = 90, P_COOL = 60, P_STUN = 20;

  localparam logic [6:0] B_L = 7'b0000001, B_R = 7'b0000010, B_U = 7'b0000100;
  localparam logic [6:0] B_A = 7'b0010000, B_S = 7'b0100000, B_0 = 7'b0000000;

  logic       clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, hit = 1'b0;
  logic [6:0] ci = '0;
  logic [3:0] state;
  logic [1:0] move_dir;
  logic       attack_live, shield_up, airborne, crouching, shield_ready, hit_taken, blocked;

  int checks = 0, failures = 0;
  bit chk_en = 0;

  // Frame-level model: remaining frames for timed states, usage count up for shield.
  logic [3:0] m_state;
  int m_left, m_used, m_cool, m_jdir, m_dir;
  bit m_prev, m_pend, m_ht, m_bl;

  player_action_fsm #(
    .JUMP_FRAMES(P_JUMP), .WINDUP_FRAMES(P_WIND), .ACTIVE_FRAMES(P_ACT),
    .RECOVER_FRAMES(P_REC), .SHIELD_MAX(P_SMAX), .SHIELD_COOLDOWN(P_COOL),
    .STUN_FRAMES(P_STUN)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .controller_inputs(ci), .hit(hit),
    .state(state), .move_dir(move_dir), .attack_live(attack_live), .shield_up(shield_up),
    .airborne(airborne), .crouching(crouching), .shield_ready(shield_ready),
    .hit_taken(hit_taken), .blocked(blocked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = ST_IDLE; m_left = 0; m_used = 0; m_cool = 0; m_jdir = 0; m_dir = 0;
    m_prev = 0; m_pend = 0; m_ht = 0; m_bl = 0;
  endtask

  task automatic model_tick(input logic [6:0] b, input bit h_in);
    bit h, edge_a, rdy;
    int d;
    h = m_pend | h_in;
    m_pend = 0;
    edge_a = b[4] && !m_prev;
    m_prev = b[4];
    d = (b[0] && !b[1]) ? 1 : ((b[1] && !b[0]) ? 2 : 0);
    rdy = (m_cool == 0);
    if (m_cool > 0) m_cool--;
    m_ht = 0; m_bl = 0;
    if (m_state == ST_SHIELD) begin
      if (h) m_bl = 1;
      m_used++;
      if (!b[5] || m_used >= P_SMAX) begin m_state = ST_IDLE; m_cool = P_COOL; end
    end else if (h) begin
      m_state = ST_STUN; m_left = P_STUN; m_ht = 1;
    end else if (m_state == ST_IDLE || m_state == ST_WALK || m_state == ST_CROUCH) begin
      if (edge_a)            begin m_state = ST_WINDUP; m_left = P_WIND; end
      else if (b[5] && rdy)  begin m_state = ST_SHIELD; m_used = 0; end
      else if (b[2])         begin m_state = ST_JUMP; m_left = P_JUMP; m_jdir = d; end
      else if (b[3])         m_state = ST_CROUCH;
      else if (d != 0)       m_state = ST_WALK;
      else                   m_state = ST_IDLE;
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_state == ST_WINDUP)      begin m_state = ST_ACTIVE;  m_left = P_ACT; end
        else if (m_state == ST_ACTIVE) begin m_state = ST_RECOVER; m_left = P_REC; end
        else                           m_state = ST_IDLE;
      end
    end
    m_dir = (m_state == ST_WALK) ? d : ((m_state == ST_JUMP) ? m_jdir : 0);
  endtask

  task automatic cyc(input bit tk, input logic [6:0] b, input bit h);
    @(negedge clk);
    frame_tick = tk; ci = b; hit = h;
    @(posedge clk);
    #1;
    if (tk) model_tick(b, h);
    else begin m_pend = m_pend | h; m_ht = 0; m_bl = 0; end
    frame_tick = 0; hit = 0;
  endtask

  task automatic tick(input logic [6:0] b, input bit h, input int gap);
    cyc(1'b1, b, h);
    for (int g = 0; g < gap; g++) cyc(1'b0, b, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1; ci = '0; frame_tick = 0; hit = 0;
    #1 model_reset();
    chk("rst_state", state, 0);
    chk("rst_move_dir", move_dir, 0);
    chk("rst_flags", {attack_live, shield_up, airborne, crouching, hit_taken, blocked}, 0);
    chk("rst_shield_ready", shield_ready, 1);
    @(negedge clk);
    #2 reset = 0;
  endtask

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("state", state, m_state);
      chk("move_dir", move_dir, m_dir);
      chk("attack_live", attack_live, m_state == ST_ACTIVE);
      chk("shield_up", shield_up, m_state == ST_SHIELD);
      chk("airborne", airborne, m_state == ST_JUMP);
      chk("crouching", crouching, m_state == ST_CROUCH);
      chk("shield_ready", shield_ready, m_cool == 0);
      chk("hit_taken", hit_taken, m_ht);
      chk("blocked", blocked, m_bl);
      chk("pulse_excl", hit_taken & blocked, 0);
    end
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int nw, na, nr, ns, nz, n, nd;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    chk_en = 1;

    // Walking and direction resolution.
    tick(B_L, 0, 0);
    chk("walk_state", state, 1); chk("walk_dir", move_dir, 1);
    tick(B_L | B_R, 0, 1);
    chk("lr_state", state, 0); chk("lr_dir", move_dir, 0);
    tick(B_R, 0, 2);
    chk("walk_r_dir", move_dir, 2);

    // Attack held: exactly one sequence.
    nw = 0; na = 0; nr = 0;
    for (int i = 0; i < 20; i++) begin
      tick(B_A, 0, 0);
      if (state == 4) nw++;
      if (attack_live) na++;
      if (state == 6) nr++;
    end
    chk("windup_frames", nw, 3); chk("live_frames", na, 2); chk("recover_frames", nr, 6);
    chk("after_attack", state, 0);
    tick(B_0, 0, 1);
    tick(B_A, 0, 0);
    chk("repress_windup", state, 4);
    repeat (11) tick(B_0, 0, 1);
    chk("attack_done", state, 0);

    // Shield held 100 frames, then cooldown window with a stray press.
    ns = 0; nz = 0;
    for (int i = 1; i <= 160; i++) begin
      tick((i <= 100 || i == 120) ? B_S : B_0, 0, 0);
      if (state == 7) ns++;
      if (!shield_ready) nz++;
      if (i == 120) chk("shield_locked", state, 0);
    end
    chk("shield_frames", ns, 90); chk("cooldown_frames", nz, 60);
    chk("ready_again", shield_ready, 1);

    // Hit absorbed by the shield.
    tick(B_S, 0, 1);
    chk("shield_on", state, 7);
    tick(B_S, 1, 0);
    chk("blocked_pulse", blocked, 1); chk("blocked_stay", state, 7); chk("blocked_no_ht", hit_taken, 0);
    cyc(0, B_S, 0);
    chk("blocked_1clk", blocked, 0);
    tick(B_0, 0, 1);
    chk("shield_release", state, 0);

    // Hit during ACTIVE, restart at stun tick 10.
    tick(B_A, 0, 1);
    n = 0;
    while (!attack_live && n < 10) begin tick(B_0, 0, 1); n++; end
    chk("reach_active", n, 3);
    tick(B_0, 1, 0);
    chk("stun_enter", state, 8); chk("stun_ht", hit_taken, 1);
    cyc(0, B_0, 0);
    chk("ht_1clk", hit_taken, 0);
    repeat (9) tick(B_0, 0, 1);
    chk("stun_mid", state, 8);
    tick(B_0, 1, 0);
    chk("stun_restart_ht", hit_taken, 1);
    n = 1;
    while (state == 8 && n < 40) begin tick(B_0, 0, 1); if (state == 8) n++; end
    chk("stun_len", n, 20);

    // Jump with latched direction after release.
    tick(B_U | B_R, 0, 1);
    chk("jump_state", state, 3); chk("jump_dir", move_dir, 2);
    n = 1; nd = 1;
    while (state == 3 && n < 40) begin
      tick(B_0, 0, 1);
      if (state == 3) begin n++; if (move_dir == 2) nd++; end
    end
    chk("jump_len", n, 16); chk("jump_dir_held", nd, 16);
    chk("land_idle", state, 0);

    // Mid-cycle hit while airborne lands on the next tick.
    tick(B_U, 0, 1);
    tick(B_0, 0, 1);
    cyc(0, B_0, 1);
    cyc(0, B_0, 0);
    chk("pend_hold", state, 3);
    tick(B_0, 0, 0);
    chk("air_hit_stun", state, 8); chk("air_hit_ht", hit_taken, 1);
    repeat (20) tick(B_0, 0, 1);
    chk("stun_expire", state, 0);

    // Reset during WINDUP.
    tick(B_A, 0, 1);
    chk("windup_pre_rst", state, 4);
    do_reset();
    n = 0;
    for (int i = 0; i < 12; i++) begin tick(B_0, 0, 1); if (attack_live) n++; end
    chk("no_live_after_rst", n, 0);
    tick(B_L, 0, 1);
    chk("post_rst_walk", state, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/player_action_fsm.md
# player_action_fsm

Per-player action sequencer that sits between one `controller` instance and the game logic. It consumes the 7-bit debounced controller input vector and advances a fighter action state machine once per game frame: walk, crouch, jump, three-phase attack, shield with cooldown, and hit-stun. It arbitrates simultaneous button requests by fixed priority and drives registered action flags to the renderer and collision logic.

## Interface
- `JUMP_FRAMES`, 16: airborne duration in frames.
- `WINDUP_FRAMES`, 3: attack wind-up frames.
- `ACTIVE_FRAMES`, 2: attack hitbox-live frames.
- `RECOVER_FRAMES`, 6: attack recovery frames.
- `SHIELD_MAX`, 90: maximum continuous shield frames.
- `SHIELD_COOLDOWN`, 60: frames before the shield can be raised again.
- `STUN_FRAMES`, 20: hit-stun duration.
- All parameters are in the range 1–255.

Ports:
- `clk` in 1: main clock.
- `reset` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: single-cycle pulse, once per game frame.
- `controller_inputs` in 7: active-high. [0] left, [1] right, [2] up, [3] down, [4] attack, [5] shield, [6] reserved (ignored).
- `hit` in 1: single-cycle pulse from collision logic; may arrive on any cycle.
- `state` out 4: current state encoding.
- `move_dir` out 2: 00 none, 01 left, 10 right.
- `attack_live` out 1: high in ACTIVE.
- `shield_up` out 1: high in SHIELD.
- `airborne` out 1: high in JUMP.
- `crouching` out 1: high in CROUCH.
- `shield_ready` out 1: cooldown counter is zero.
- `hit_taken` out 1: one-cycle pulse when entering or restarting STUN.
- `blocked` out 1: one-cycle pulse when a hit is absorbed by the shield.

## Operation
- States: IDLE, WALK, CROUCH, JUMP, WINDUP, ACTIVE, RECOVER, SHIELD, STUN.
- State changes, counter updates and input sampling happen only on `frame_tick`. Between ticks, all registers hold, except `hit_pending`.
- `hit_pending` is set by `hit` on any cycle and cleared on the next `frame_tick`. A `hit` coincident with `frame_tick` counts for that tick.
- Attack is edge-triggered. `attack_prev` is sampled each tick, and a request is `attack & ~attack_prev`.
- Left and right pressed together count as no direction.
- Arbitration from IDLE, WALK or CROUCH, highest priority first:
  1. hit_pending → STUN
  2. attack edge → WINDUP
  3. shield and `shield_ready` → SHIELD
  4. up → JUMP
  5. down → CROUCH
  6. exactly one of left/right → WALK
  7. otherwise → IDLE
- JUMP:
  - `move_dir` is latched at takeoff and held for the whole jump.
  - Runs `JUMP_FRAMES` ticks, then goes to IDLE.
  - Attack and shield are ignored while airborne.
- Attack sequence: WINDUP (`WINDUP_FRAMES`) → ACTIVE (`ACTIVE_FRAMES`) → RECOVER (`RECOVER_FRAMES`) → IDLE. The sequence cannot be cancelled by buttons.
- SHIELD:
  - The usage counter increments each tick.
  - Exit to IDLE on shield release or when usage reaches `SHIELD_MAX`, whichever comes first.
  - On exit, load the cooldown counter with `SHIELD_COOLDOWN`.
- Cooldown decrements on every tick in every state and saturates at 0.
- Hit handling:
  - In SHIELD: pulse `blocked`, stay in SHIELD; the usage count is unaffected.
  - In any other state (including JUMP, attack phases and STUN): go to STUN, load `STUN_FRAMES`, pulse `hit_taken`.
  - A hit during STUN restarts the stun count.
- STUN: at expiry go to IDLE. Buttons held at expiry are arbitrated on the following tick.
- `move_dir` is the resolved direction in WALK, the latched takeoff direction in JUMP, and 00 in all other states.
- Counters are 8-bit unsigned down-counters that load N and expire when they reach 1 on a tick. A state with parameter N therefore lasts exactly N ticks.

## Timing
- All outputs are registered. They update on the `clk` edge after the edge that samples `frame_tick` (latency: 1 clk).
- Reset values:
  - `state` = IDLE.
  - `move_dir` = 00.
  - All flags and pulses = 0, except `shield_ready` = 1.
  - All counters = 0; `attack_prev` = 0; `hit_pending` = 0.
- `reset` asserted mid-sequence aborts immediately, with no pulse emitted. After release, the first tick arbitrates from IDLE.
- `hit_taken` and `blocked` are high for exactly one `clk`, never both high together.
- Back-to-back ticks (`frame_tick` on consecutive clocks) are legal and each one advances the machine.

## Structure
- Package `player_action_pkg` holds:
  - State encoding localparams.
  - Controller bit indices (`BTN_LEFT`=0 … `BTN_SHIELD`=5).
  - `move_dir` codes.
- Sub-module `action_timer`: 8-bit loadable down-counter with `load`, `value`, `tick` and `expire` ports.
  - One instance serves as the shared phase timer (jump, attack phases, stun, shield usage).
  - One instance serves as the shield cooldown.

## Test plan
- Reset, then a tick with left=1 → WALK, `move_dir`=01. Left+right → IDLE, `move_dir`=00.
- Attack held for 20 ticks → exactly one sequence: 3 ticks WINDUP, 2 ticks `attack_live`=1, 6 ticks RECOVER, then IDLE. No second attack until release and re-press.
- Shield held for 100 ticks → SHIELD for 90 ticks, then IDLE with `shield_ready`=0 for 60 ticks. A shield press in that window has no effect.
- Hit during SHIELD → `blocked` pulses for 1 clk and the state stays SHIELD. Hit during ACTIVE → STUN for 20 ticks with `hit_taken` pulsed. A second hit at stun tick 10 restarts the count to 20.
- Up+right → JUMP with `move_dir`=10 for 16 ticks, even if right is released. A hit arriving mid-cycle between ticks while airborne → STUN on the next tick.
- `reset` pulsed during WINDUP → all outputs return to reset values within the same cycle, and `attack_live` never asserts.
